// File: rtl/neuro_pkg.sv
// Shared constants and types for the Hebbian weight store: sizes, weight range,
// trainer state encoding and the reference letter patterns (bit index = row*5+col).
package neuro_pkg;

   localparam int N    = 25;
   localparam int NW   = 625;
   localparam int WW   = 4;
   localparam int AW   = 10;
   localparam int WMIN = -8;
   localparam int WMAX = 7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_LEARN,
      S_DRAIN
   } state_t;

   localparam logic [N-1:0] PAT_D = 25'b01110_10010_10010_10010_01111;
   localparam logic [N-1:0] PAT_C = 25'b11110_00001_00001_00001_11110;
   localparam logic [N-1:0] PAT_J = 25'b00111_01001_01000_01000_11100;
   localparam logic [N-1:0] PAT_M = 25'b10001_10001_10101_11011_10001;

endpackage

// File: rtl/hebb_sat_add.sv
// Adds +1 (agree) or -1 (disagree) to a signed weight and clamps the result
// to the representable weight range.
module hebb_sat_add
   import neuro_pkg::*;
(
   input  logic signed [WW-1:0] w,
   input  logic                 agree,
   output logic signed [WW-1:0] q
);

   logic [WW:0] step;
   logic [WW:0] sum;

   always_comb begin
      step = '1;
      if (agree) step = (WW+1)'(1);
      sum = {w[WW-1], w} + step;
      // top two bits disagree only when the one-bit-wider sum left the range
      if (sum[WW] != sum[WW-1]) begin
         q = sum[WW] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
      end else begin
         q = sum[WW-1:0];
      end
   end

endmodule

// File: rtl/hebb_trainer.sv
// Hebbian learning engine: clears or read-modify-writes all N*N weights of the
// external synchronous weight RAM, one address per cycle.
module hebb_trainer #(
   parameter int N         = 25,
   parameter int WW        = 4,
   parameter bit ZERO_DIAG = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_req,
   input  logic                 pat_valid,
   output logic                 pat_ready,
   input  logic [N-1:0]         pat,
   output logic                 w_re,
   output logic [9:0]           w_raddr,
   input  logic signed [WW-1:0] w_rdata,
   output logic                 w_we,
   output logic [9:0]           w_waddr,
   output logic signed [WW-1:0] w_wdata,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           n_learned
);

   localparam int AW = neuro_pkg::AW;
   localparam int NW = neuro_pkg::NW;

   neuro_pkg::state_t state_q, state_d;

   logic [AW-1:0]        cnt;
   logic [AW-1:0]        wr_addr;
   logic [4:0]           k, m;
   logic [N-1:0]         p_reg;
   logic                 wr_v;
   logic                 agr_q;
   logic                 diag_q;
   logic                 last;
   logic signed [WW-1:0] sat_q;
   logic signed [WW-1:0] wdat;

   hebb_sat_add u_sat (
      .w     (w_rdata),
      .agree (agr_q),
      .q     (sat_q)
   );

   always_comb begin
      state_d   = state_q;
      pat_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      w_re      = 1'b0;
      w_we      = 1'b0;
      w_raddr   = cnt;
      w_waddr   = wr_addr;
      w_wdata   = '0;
      last      = (cnt == AW'(NW-1));
      wdat      = (ZERO_DIAG && diag_q) ? '0 : sat_q;
      unique case (state_q)
         neuro_pkg::S_IDLE: begin
            busy      = 1'b0;
            pat_ready = !clear_req;
            if (clear_req)      state_d = neuro_pkg::S_CLEAR;
            else if (pat_valid) state_d = neuro_pkg::S_LEARN;
         end
         neuro_pkg::S_CLEAR: begin
            w_we    = 1'b1;
            w_waddr = cnt;
            if (last) state_d = neuro_pkg::S_DRAIN;
         end
         neuro_pkg::S_LEARN: begin
            w_re    = 1'b1;
            w_we    = wr_v;
            w_wdata = wdat;
            if (last) state_d = neuro_pkg::S_DRAIN;
         end
         neuro_pkg::S_DRAIN: begin
            // done coincides with the trailing write of a learn pass
            done    = 1'b1;
            w_we    = wr_v;
            w_wdata = wdat;
            state_d = neuro_pkg::S_IDLE;
         end
         default: state_d = neuro_pkg::S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= neuro_pkg::S_IDLE;
         cnt       <= '0;
         wr_addr   <= '0;
         k         <= '0;
         m         <= '0;
         p_reg     <= '0;
         wr_v      <= 1'b0;
         agr_q     <= 1'b0;
         diag_q    <= 1'b0;
         n_learned <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            neuro_pkg::S_IDLE: begin
               cnt  <= '0;
               k    <= '0;
               m    <= '0;
               wr_v <= 1'b0;
               if (!clear_req && pat_valid) p_reg <= pat;
            end
            neuro_pkg::S_CLEAR: begin
               cnt <= cnt + AW'(1);
               if (last) n_learned <= '0;
            end
            neuro_pkg::S_LEARN: begin
               wr_v    <= 1'b1;
               wr_addr <= cnt;
               agr_q   <= (p_reg[k] == p_reg[m]);
               diag_q  <= (k == m);
               cnt     <= cnt + AW'(1);
               if (m == 5'(N-1)) begin
                  m <= '0;
                  k <= k + 5'd1;
               end else begin
                  m <= m + 5'd1;
               end
               if (last && n_learned != 8'hFF) n_learned <= n_learned + 8'd1;
            end
            neuro_pkg::S_DRAIN: begin
               wr_v <= 1'b0;
               cnt  <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hebb_trainer.sv
// Bench for hebb_trainer: behavioural weight RAM plus an arithmetic model of
// the Hebbian weight table, exercised with fixed letters and random patterns.
module tb_hebb_trainer;
   import neuro_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              clear_req;
   logic              pat_valid;
   logic              pat_ready;
   logic [24:0]       pat;
   logic              w_re;
   logic [9:0]        w_raddr;
   logic signed [3:0] w_rdata;
   logic              w_we;
   logic [9:0]        w_waddr;
   logic signed [3:0] w_wdata;
   logic              busy;
   logic              done;
   logic [7:0]        n_learned;

   int tests = 0;
   int fails = 0;
   int ref_w [625];
   int ref_n;
   logic signed [3:0] mem [0:1023];

   always #5 clk = ~clk;

   hebb_trainer #(.N(25), .WW(4), .ZERO_DIAG(1'b0)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear_req (clear_req),
      .pat_valid (pat_valid),
      .pat_ready (pat_ready),
      .pat       (pat),
      .w_re      (w_re),
      .w_raddr   (w_raddr),
      .w_rdata   (w_rdata),
      .w_we      (w_we),
      .w_waddr   (w_waddr),
      .w_wdata   (w_wdata),
      .busy      (busy),
      .done      (done),
      .n_learned (n_learned)
   );

   always @(posedge clk) begin
      if (w_we) mem[w_waddr] <= w_wdata;
      if (w_re) w_rdata <= mem[w_raddr];
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      tests++;
      if (obs != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < 625; i++) ref_w[i] = 0;
      ref_n = 0;
   endfunction

   function automatic void model_learn(input logic [24:0] p);
      int v;
      for (int r = 0; r < 25; r++) begin
         for (int c = 0; c < 25; c++) begin
            v = ref_w[r*25+c] + ((p[r] == p[c]) ? 1 : -1);
            if (v > 7) v = 7;
            if (v < -8) v = -8;
            ref_w[r*25+c] = v;
         end
      end
      if (ref_n < 255) ref_n++;
   endfunction

   // Follows one pass from the cycle after acceptance up to the done cycle.
   task automatic watch(input bit learn, input bit noise, input string tag);
      int  cyc = 0;
      int  wr = 0;
      int  rd = 0;
      int  bad = 0;
      bit  got = 1'b0;
      while (!got && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (w_re) begin
            if (w_raddr != 10'(rd)) bad++;
            rd++;
         end
         if (w_we) begin
            if (wr >= 625 || w_waddr != 10'(wr)) bad++;
            else if (int'(w_wdata) != (learn ? ref_w[wr] : 0)) bad++;
            wr++;
         end
         if (done) begin
            got = 1'b1;
            check_eq({tag, "_ready_at_done"}, int'(pat_ready), 0);
         end
         if (noise) begin
            if (done) begin
               clear_req = 1'b0;
               pat_valid = 1'b0;
            end else begin
               clear_req = 1'($urandom);
               pat_valid = 1'($urandom);
               pat       = 25'($urandom);
            end
         end
      end
      check_eq({tag, "_cycles"}, cyc, 626);
      check_eq({tag, "_writes"}, wr, 625);
      check_eq({tag, "_reads"}, rd, learn ? 625 : 0);
      check_eq({tag, "_bad_wr"}, bad, 0);
      check_eq({tag, "_n_learned"}, int'(n_learned), ref_n);
   endtask

   task automatic do_clear(input string tag);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      clear_req = 1'b1;
      model_clear();
      @(posedge clk);
      #1 clear_req = 1'b0;
      watch(1'b0, 1'b1, tag);
   endtask

   task automatic do_learn(input logic [24:0] p, input string tag);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      pat       = p;
      pat_valid = 1'b1;
      model_learn(p);
      @(posedge clk);
      #1 pat_valid = 1'b0;
      watch(1'b1, 1'b1, tag);
   endtask

   task automatic dump_check(input string tag);
      int bad = 0;
      @(posedge clk);
      #1;
      for (int a = 0; a < 625; a++) if (int'(mem[a]) != ref_w[a]) bad++;
      check_eq({tag, "_dump"}, bad, 0);
   endtask

   initial begin
      int bad;
      bit hit;
      for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom_range(1, 15));
      rst = 1'b0; clear_req = 1'b0; pat_valid = 1'b0; pat = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_we", int'(w_we), 0);
      check_eq("rst_re", int'(w_re), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_n_learned", int'(n_learned), 0);
      check_eq("rst_ready", int'(pat_ready), 1);
      clear_req = 1'b1;
      #1 check_eq("rst_ready_clr", int'(pat_ready), 0);
      clear_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      do_clear("clr0");
      dump_check("clr0");

      do_learn(PAT_D, "learnD");
      dump_check("learnD");
      check_eq("D_w0", int'(mem[0]), 1);
      check_eq("D_w1", int'(mem[1]), 1);
      check_eq("D_w4", int'(mem[4]), -1);
      check_eq("D_w24", int'(mem[24]), -1);

      do_clear("clr1");
      do_learn(PAT_D, "dcjm_D");
      do_learn(PAT_C, "dcjm_C");
      do_learn(PAT_J, "dcjm_J");
      do_learn(PAT_M, "dcjm_M");
      dump_check("dcjm");
      check_eq("dcjm_w0", int'(mem[0]), 4);
      check_eq("dcjm_w312", int'(mem[312]), 4);

      do_clear("clr2");
      for (int i = 0; i < 9; i++) do_learn(PAT_D, "satD");
      dump_check("satD");
      check_eq("sat_w0", int'(mem[0]), 7);
      check_eq("sat_w1", int'(mem[1]), 7);
      check_eq("sat_w4", int'(mem[4]), -8);
      check_eq("sat_n", int'(n_learned), 9);

      // clear and pattern offered together: clear wins, pattern taken after done
      @(negedge clk);
      clear_req = 1'b1; pat_valid = 1'b1; pat = PAT_D;
      #1 check_eq("coll_ready", int'(pat_ready), 0);
      model_clear();
      @(posedge clk);
      #1 clear_req = 1'b0;
      watch(1'b0, 1'b0, "coll_clr");
      model_learn(PAT_D);
      @(negedge clk);
      check_eq("coll_idle_busy", int'(busy), 0);
      check_eq("coll_idle_ready", int'(pat_ready), 1);
      @(posedge clk);
      #1 pat_valid = 1'b0;
      watch(1'b1, 1'b1, "coll_learn");
      dump_check("coll");

      // reset in the middle of a learn pass
      @(negedge clk);
      pat = PAT_M; pat_valid = 1'b1;
      @(posedge clk);
      #1 pat_valid = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 2000 && !hit; c++) begin
         @(negedge clk);
         if (w_we && w_waddr == 10'd300) hit = 1'b1;
      end
      check_eq("mid_reach300", int'(hit), 1);
      rst = 1'b0;
      #1;
      check_eq("mid_we", int'(w_we), 0);
      check_eq("mid_busy", int'(busy), 0);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy || w_we) bad++;
      end
      check_eq("mid_quiet", bad, 0);
      rst = 1'b1;
      do_clear("post_rst_clr");
      do_learn(PAT_D, "post_rst_D");
      dump_check("post_rst");

      for (int r = 0; r < 3; r++) begin
         do_clear("rnd_clr");
         repeat ($urandom_range(2, 5)) do_learn(25'($urandom), "rnd_learn");
         dump_check("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hebb_trainer.md
Name: hebb_trainer

Overview:
- Sequential Hebbian learning engine and the writer side of the 25x25 weight store that the recall engine reads.
- Accepts one 25-bit pattern (a 5x5 LED image, bit index = row*5+col) per handshake.
- Walks all 625 weights, read-modify-writes each with +1 (pixels equal) or -1 (pixels differ), and saturates to 4-bit signed.
- Also supports a clear command that zeroes the whole store, so patterns are learned at run time instead of hardwired.

Parameters:
- N, 25, neurons per pattern
- WW, 4, weight width (signed)
- ZERO_DIAG, 0, when 1 diagonal weights (k==m) are written 0 instead of accumulated

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- clear_req  in  1  request to zero all weights, sampled in IDLE
- pat_valid  in  1  pattern offered
- pat_ready  out  1  = (state==IDLE) && !clear_req
- pat  in  25  pattern bits, captured on pat_valid&&pat_ready
- w_re  out  1  weight RAM read enable
- w_raddr  out  10  read address k*25+m
- w_rdata  in  4  signed read data, valid 1 cycle after w_re
- w_we  out  1  weight RAM write enable
- w_waddr  out  10  write address
- w_wdata  out  4  signed write data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last write of a CLEAR or LEARN pass
- n_learned  out  8  patterns learned since last clear, saturates at 255

Behaviour:
- Reset (rst=0, async) forces state IDLE; all outputs 0 except pat_ready, which is 1 if clear_req=0.
- Reset mid-pass aborts the pass immediately; RAM contents are then undefined; no done pulse.
- Clock domain: everything on posedge clk; the weight RAM is synchronous, with 1-cycle read latency.
- FSM states: IDLE, CLEAR, LEARN, DRAIN.
- IDLE:
  - clear_req=1: go to CLEAR. Clear takes priority; a pattern offered in the same cycle is not accepted.
  - Else pat_valid=1: latch pat into p_reg, go to LEARN.
- Address generation: k and m counters, both 0..24. m increments each cycle; on m==24, m wraps to 0 and k increments. Address = k*25+m, produced by an incrementing counter (0..624); no multiplier.
- CLEAR:
  - One write per cycle: w_we=1, w_wdata=0, addresses 0..624. No reads.
  - After 625 cycles: done=1 for one cycle, n_learned=0, return to IDLE.
  - Total: 625 cycles in CLEAR, then done.
- LEARN (2-stage pipeline):
  - Cycle t: w_re=1, w_raddr=a.
  - Cycle t+1: w_we=1, w_waddr=a, w_wdata=sat(w_rdata + d). d=+1 if p_reg[k]==p_reg[m], else -1, using the k,m registered with a.
  - Issue one read per cycle for a=0..624, then go to DRAIN for the final write.
  - A read and a write in the same cycle always target different addresses (a+1 vs a), so there is no hazard.
  - After the write of address 624: done pulse, n_learned+1 (saturating), return to IDLE.
  - Total: 626 cycles from accept to done.
- Saturation: sum computed in 5-bit signed, clamped to [-8,+7].
- ZERO_DIAG=1: for k==m, w_wdata=0 in both LEARN and CLEAR.
- p_reg is held stable for the whole pass. pat, pat_valid and clear_req are ignored while busy; clear_req is level-sampled only in IDLE.
- done and pat_ready are never high in the same cycle as the done pulse, because the return to IDLE is registered.
- Weight semantics: after a clear and learning patterns P1..Pn (n<=7), w[k*25+m] = sum over patterns of (Pi[k]==Pi[m] ? +1 : -1). This equals the recall engine's hardwired weight table for the D, J, C, M set.

Decomposition:
- neuro_pkg holds: N=25, NW=625, WW=4, WMIN=-8, WMAX=7, state enum, the D/C/J/M 25-bit pattern constants (shared with recall and bench).
- One sub-module, hebb_sat_add: combinational; inputs signed [3:0] w and 1-bit agree; output the clamped signed [3:0] result.

Test Plan:
- Clear after reset -> exactly 625 writes of 0 to addresses 0..624, done at cycle 626 after accept, n_learned=0; a RAM dump is all zeros.
- Clear, then learn D=25'b0111010010100101001001111 -> w[1]=+1 (bits 0,1 both 1), w[4]=-1, w[24]=-1, w[0]=+1; 626 cycles accept-to-done; n_learned=1.
- Clear, then learn D, C, J, M in sequence -> all 625 weights equal the recall engine's 4-pattern table, e.g. w[0]=+4, w[12*25+12]=+4.
- Clear, then learn D 9 times -> diagonal and agreeing weights read +7 (saturated after 7); w[4]=-8 (saturated after 8); n_learned=9.
- clear_req and pat_valid asserted together in IDLE -> pat_ready=0 that cycle, CLEAR runs, the pattern is taken on the cycle after done; with pat_valid held high, LEARN starts then.
- rst pulsed low at address 300 of a LEARN pass -> w_we and busy drop to 0 asynchronously, no done pulse; the following clear plus learn of D gives a correct D table.
